// File: rtl/aes_pkg.sv
// Shared AES output-path types: byte type, block size and the FIFO storage entry.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int AES_BLOCK_BYTES = 16;

  typedef struct packed {
    logic  last;
    byte_t data;
  } fifo_entry_t;

endpackage

// File: rtl/mod_fifo_mem.sv
// FIFO storage: DEPTH x (byte + last tag), synchronous write, asynchronous read, no reset.
// Kept separate so a RAM macro can be dropped in later.
module mod_fifo_mem
  import aes_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [AW-1:0] waddr_i,
  input  fifo_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fifo_entry_t rdata_o
);

  fifo_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mod_fifo_out.sv
// Output byte FIFO behind the AES256 16-to-1 serializer; pulls bytes via req_fifo/reg_empty,
// tags the last byte of each block. Optional MOD_FIFO_OUT_LEVEL_EN adds level/overflow_err ports.
module mod_fifo_out
  import aes_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_empty,
  input  byte_t                  i_byte,
  output logic                   req_fifo,
  output byte_t                  o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   fifo_full,
  output logic                   fifo_empty
`ifdef MOD_FIFO_OUT_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          pending_q;

  logic          push, pop, last_tag;
  logic [CW:0]   credit;
  fifo_entry_t   wr_entry, rd_entry;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // Credit ignores a same-cycle pop, so a granted request always has a free slot.
  assign credit   = {1'b0, count_q} + (CW+1)'(pending_q);
  assign req_fifo = !reset && !reg_empty && (credit < (CW+1)'(DEPTH));

  // The full guard only matters on a design error; the credit rule makes it unreachable.
  assign push     = pending_q && !fifo_full;
  assign o_valid  = !fifo_empty;
  assign pop      = o_valid && i_ready;
  assign last_tag = (blk_cnt_q == BW'(BLOCK_BYTES - 1));

  assign wr_entry.data = i_byte;
  assign wr_entry.last = last_tag;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    blk_cnt_d = blk_cnt_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      blk_cnt_d = last_tag ? '0 : blk_cnt_q + BW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      blk_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      blk_cnt_q <= blk_cnt_d;
      pending_q <= req_fifo;
    end
  end

  mod_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Storage is not reset, so mask the head while empty.
  assign o_data = fifo_empty ? '0 : rd_entry.data;
  assign o_last = fifo_empty ? 1'b0 : rd_entry.last;

`ifdef MOD_FIFO_OUT_LEVEL_EN
  logic overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       overflow_q <= 1'b0;
    else if (pending_q && fifo_full) overflow_q <= 1'b1;
  end

  assign level        = count_q;
  assign overflow_err = overflow_q;
`endif

endmodule

// File: tb/tb_mod_fifo_out.sv
// Directed bench for mod_fifo_out: per-cycle table for one block plus hand-written corner sequences.
module tb_mod_fifo_out;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reg_empty = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_ready = 1'b0;
  logic       req_fifo, o_valid, o_last, fifo_full, fifo_empty;
  logic [7:0] o_data;
`ifdef MOD_FIFO_OUT_LEVEL_EN
  logic [5:0] level;
  logic       overflow_err;
`endif

  int chk = 0;
  int err = 0;

  logic [7:0] up_q[$];
  logic       req_s;

  always #5 clk = ~clk;

  mod_fifo_out dut (
    .clk(clk), .reset(reset), .reg_empty(reg_empty), .i_byte(i_byte),
    .req_fifo(req_fifo), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef MOD_FIFO_OUT_LEVEL_EN
    , .level(level), .overflow_err(overflow_err)
`endif
  );

  // Upstream serializer model: a request sampled on an edge presents its byte just after that
  // edge, and reg_empty rises on the edge that takes the last byte.
  initial begin
    forever begin
      @(negedge clk);
      req_s = req_fifo;
      @(posedge clk);
      #1;
      if (reset) begin
        up_q.delete();
        reg_empty = 1'b1;
      end else if (req_s) begin
        if (up_q.size() > 0) i_byte = up_q.pop_front();
        if (up_q.size() == 0) reg_empty = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) up_q.push_back(base + 8'(i));
    reg_empty = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset   = 1'b1;
    i_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Follow the output stream until byte index 'stop', checking data and block tags.
  task automatic drain(input logic [7:0] base, input int start, input int stop,
                       input int budget, input bit lvl_chk);
    int idx = start;
    int cyc = 0;
    while (idx < stop && cyc < budget) begin
      @(negedge clk);
      cyc++;
`ifdef MOD_FIFO_OUT_LEVEL_EN
      if (lvl_chk) check("level_le2", 32'(level <= 6'd2), 32'd1);
`else
      if (lvl_chk) check("not_full", 32'(fifo_full), 32'd0);
`endif
      if (o_valid && i_ready) begin
        check($sformatf("data[%0d]", idx), 32'(o_data), 32'(base + 8'(idx)));
        check($sformatf("last[%0d]", idx), 32'(o_last), 32'((idx % 16) == 15));
        idx++;
      end
    end
    if (idx < stop) check("drain_timeout", 32'(idx), 32'(stop));
  endtask

  typedef struct {
    logic       req;
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       empty;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int nreq;

    // Single-block schedule relative to the first request cycle
    for (int k = 0; k < 19; k++) begin
      tbl[k].req   = (k < 16);
      tbl[k].vld   = (k >= 2 && k <= 17);
      tbl[k].data  = tbl[k].vld ? 8'(k - 2) : 8'h00;
      tbl[k].last  = (k == 17);
      tbl[k].empty = !tbl[k].vld;
    end

    // Reset asserted mid-cycle takes effect immediately
    #2 reset = 1'b1;
    #1;
    check("rst_req", 32'(req_fifo), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
`ifdef MOD_FIFO_OUT_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
`endif
    step();
    step();
    reset = 1'b0;

    // Single block, table-driven per cycle
    step();
    load(8'h00, 16);
    i_ready = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      check($sformatf("blk_req[%0d]", k), 32'(req_fifo), 32'(tbl[k].req));
      check($sformatf("blk_vld[%0d]", k), 32'(o_valid), 32'(tbl[k].vld));
      check($sformatf("blk_data[%0d]", k), 32'(o_data), 32'(tbl[k].data));
      check($sformatf("blk_last[%0d]", k), 32'(o_last), 32'(tbl[k].last));
      check($sformatf("blk_empty[%0d]", k), 32'(fifo_empty), 32'(tbl[k].empty));
    end

    // Backpressure to full with three blocks available
    do_reset();
    load(8'h00, 48);
    nreq = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_fifo) nreq++;
      if (fifo_full) break;
    end
    check("bp_nreq", 32'(nreq), 32'd32);
    check("bp_full", 32'(fifo_full), 32'd1);
    check("bp_req_off", 32'(req_fifo), 32'd0);
`ifdef MOD_FIFO_OUT_LEVEL_EN
    check("bp_level", 32'(level), 32'd32);
`endif
    step();
    @(negedge clk);
    check("bp_hold_req", 32'(req_fifo), 32'd0);
    check("bp_hold_full", 32'(fifo_full), 32'd1);
    step();
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_data", 32'(o_data), 32'h00);
    check("bp_pop_req", 32'(req_fifo), 32'd0);
    step();
    i_ready = 1'b0;
    @(negedge clk);
    check("bp_req_back", 32'(req_fifo), 32'd1);
    check("bp_not_full", 32'(fifo_full), 32'd0);
    step();
    i_ready = 1'b1;
    drain(8'h00, 1, 48, 300, 1'b0);
    step();
    step();
    check("bp_empty", 32'(fifo_empty), 32'd1);
`ifdef MOD_FIFO_OUT_LEVEL_EN
    check("bp_level0", 32'(level), 32'd0);
    check("bp_ovf", 32'(overflow_err), 32'd0);
`endif

    // Streaming push/pop through pointer wrap
    do_reset();
    load(8'h00, 40);
    i_ready = 1'b1;
    drain(8'h00, 0, 40, 200, 1'b1);
    step();
    step();
    check("wrap_empty", 32'(fifo_empty), 32'd1);
    check("wrap_up_done", 32'(up_q.size()), 32'd0);

    // Reset while a requested byte is in flight
    do_reset();
    load(8'hA0, 16);
    @(negedge clk);
    check("pr_req", 32'(req_fifo), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("pr_req_rst", 32'(req_fifo), 32'd0);
    check("pr_vld_rst", 32'(o_valid), 32'd0);
    check("pr_empty_rst", 32'(fifo_empty), 32'd1);
    check("pr_full_rst", 32'(fifo_full), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("pr_not_written", 32'(fifo_empty), 32'd1);
    step();
    load(8'hB0, 16);
    i_ready = 1'b1;
    drain(8'hB0, 0, 16, 100, 1'b1);
`ifdef MOD_FIFO_OUT_LEVEL_EN
    check("pr_ovf", 32'(overflow_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
